// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// FSM state codes, datapath select encodings and instruction classes.
package control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_JR  = 6'h08;

   typedef logic [3:0] state_t;

   localparam state_t ST_FETCH    = 4'd0;
   localparam state_t ST_DECODE   = 4'd1;
   localparam state_t ST_EXEC_R   = 4'd2;
   localparam state_t ST_WB_R     = 4'd3;
   localparam state_t ST_EXEC_I   = 4'd4;
   localparam state_t ST_WB_I     = 4'd5;
   localparam state_t ST_MEM_ADDR = 4'd6;
   localparam state_t ST_MEM_RD   = 4'd7;
   localparam state_t ST_MEM_WB   = 4'd8;
   localparam state_t ST_MEM_WR   = 4'd9;
   localparam state_t ST_BRANCH   = 4'd10;
   localparam state_t ST_JUMP     = 4'd11;
   localparam state_t ST_JR       = 4'd12;
   localparam state_t ST_TRAP     = 4'd13;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_XOR = 3'b010,
      ALU_SLT = 3'b011
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_ALU    = 2'b00,
      PC_ALUOUT = 2'b01,
      PC_JUMP   = 2'b10,
      PC_REGA   = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      DST_RT  = 2'b00,
      DST_RD  = 2'b01,
      DST_R31 = 2'b10
   } reg_dst_e;

   typedef enum logic [1:0] {
      WD_ALUOUT = 2'b00,
      WD_MDR    = 2'b01,
      WD_PC     = 2'b10
   } mem_to_reg_e;

   // Bit positions of the one-hot instruction class vector.
   localparam int C_ADD  = 0;
   localparam int C_SUB  = 1;
   localparam int C_SLT  = 2;
   localparam int C_JR   = 3;
   localparam int C_LW   = 4;
   localparam int C_SW   = 5;
   localparam int C_ADDI = 6;
   localparam int C_XORI = 7;
   localparam int C_BNE  = 8;
   localparam int C_J    = 9;
   localparam int C_JAL  = 10;
   localparam int CLS_W  = 11;

   typedef logic [CLS_W-1:0] cls_t;

   typedef struct packed {
      logic       pc_we;
      logic       ir_we;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       mem_re;
      logic       mem_we;
      logic       iord;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       imm_zext;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/funct classifier: one-hot instruction class plus a
// legal flag; an all-zero class means the instruction is not supported.
module control_decode
   import control_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic       legal
);

   always_comb begin
      // NOTE: default every combinational output first so no path infers a latch.
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cls[C_ADD] = 1'b1;
               FN_SUB:  cls[C_SUB] = 1'b1;
               FN_SLT:  cls[C_SLT] = 1'b1;
               FN_JR:   cls[C_JR]  = 1'b1;
               default: cls        = '0;
            endcase
         end
         OP_LW:   cls[C_LW]   = 1'b1;
         OP_SW:   cls[C_SW]   = 1'b1;
         OP_ADDI: cls[C_ADDI] = 1'b1;
         OP_XORI: cls[C_XORI] = 1'b1;
         OP_BNE:  cls[C_BNE]  = 1'b1;
         OP_J:    cls[C_J]    = 1'b1;
         OP_JAL:  cls[C_JAL]  = 1'b1;
         default: cls         = '0;
      endcase
   end

   assign legal = |cls;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM driving every datapath enable and select.
// Define CONTROL_PERF_EN to add cycle_cnt/instr_cnt performance counters.
module multicycle_control
   import control_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
`ifdef CONTROL_PERF_EN
   , parameter int PERF_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       ir_we,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       mem_re,
   output logic       mem_we,
   output logic       iord,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       imm_zext,
   output logic [2:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal,
   output logic [3:0] state
`ifdef CONTROL_PERF_EN
   , output logic [PERF_W-1:0] cycle_cnt
   , output logic [PERF_W-1:0] instr_cnt
`endif
);

   state_t state_q, state_d;
   cls_t   cls_q, cls_d, dec_cls;
   logic   dec_legal;
   ctrl_t  ctl, ctl_o;

   control_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .cls    (dec_cls),
      .legal  (dec_legal)
   );

   // The class is captured in DECODE so later states never re-decode the IR.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      case (state_q)
         ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            cls_d = dec_cls;
            if (!dec_legal)                                   state_d = ST_TRAP;
            else if (dec_cls[C_ADD] | dec_cls[C_SUB] | dec_cls[C_SLT]) state_d = ST_EXEC_R;
            else if (dec_cls[C_JR])                           state_d = ST_JR;
            else if (dec_cls[C_LW] | dec_cls[C_SW])           state_d = ST_MEM_ADDR;
            else if (dec_cls[C_ADDI] | dec_cls[C_XORI])       state_d = ST_EXEC_I;
            else if (dec_cls[C_BNE])                          state_d = ST_BRANCH;
            else                                              state_d = ST_JUMP;
         end
         ST_EXEC_R:   state_d = ST_WB_R;
         ST_EXEC_I:   state_d = ST_WB_I;
         ST_MEM_ADDR: state_d = cls_q[C_LW] ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
         ST_WB_R, ST_WB_I, ST_MEM_WB,
         ST_BRANCH, ST_JUMP, ST_JR:  state_d = ST_FETCH;
         ST_TRAP:     state_d = HALT_ON_ILLEGAL ? ST_TRAP : ST_FETCH;
         default:     state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q <= ST_FETCH;
         cls_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
   end

   always_comb begin
      ctl = '0;
      case (state_q)
         ST_FETCH: begin
            ctl.mem_re    = 1'b1;
            ctl.alu_src_b = 2'b01;
            ctl.ir_we     = mem_ready;
            ctl.pc_we     = mem_ready;
         end
         ST_DECODE:   ctl.alu_src_b = 2'b11;
         ST_EXEC_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = cls_q[C_SUB] ? ALU_SUB : cls_q[C_SLT] ? ALU_SLT : ALU_ADD;
         end
         ST_WB_R: begin
            ctl.reg_we  = 1'b1;
            ctl.reg_dst = DST_RD;
         end
         ST_EXEC_I: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            ctl.imm_zext  = cls_q[C_XORI];
            ctl.alu_op    = cls_q[C_XORI] ? ALU_XOR : ALU_ADD;
         end
         ST_WB_I, ST_MEM_WB: begin
            ctl.reg_we     = 1'b1;
            ctl.reg_dst    = DST_RT;
            ctl.mem_to_reg = (state_q == ST_MEM_WB) ? WD_MDR : WD_ALUOUT;
         end
         ST_MEM_ADDR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
         end
         ST_MEM_RD: begin
            ctl.mem_re = 1'b1;
            ctl.iord   = 1'b1;
         end
         ST_MEM_WR: begin
            ctl.mem_we = 1'b1;
            ctl.iord   = 1'b1;
         end
         ST_BRANCH: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = ALU_SUB;
            ctl.pc_src    = PC_ALUOUT;
            ctl.pc_we     = ~zero;
         end
         ST_JUMP: begin
            ctl.pc_we  = 1'b1;
            ctl.pc_src = PC_JUMP;
            if (cls_q[C_JAL]) begin
               ctl.reg_we     = 1'b1;
               ctl.reg_dst    = DST_R31;
               ctl.mem_to_reg = WD_PC;
            end
         end
         ST_JR: begin
            ctl.pc_we  = 1'b1;
            ctl.pc_src = PC_REGA;
         end
         ST_TRAP:     ctl.illegal = 1'b1;
         default:     ctl = '0;
      endcase
   end

   // Outputs are forced quiet for the whole reset cycle so nothing is written.
   assign ctl_o      = reset ? '0 : ctl;
   assign pc_we      = ctl_o.pc_we;
   assign ir_we      = ctl_o.ir_we;
   assign reg_we     = ctl_o.reg_we;
   assign reg_dst    = ctl_o.reg_dst;
   assign mem_to_reg = ctl_o.mem_to_reg;
   assign mem_re     = ctl_o.mem_re;
   assign mem_we     = ctl_o.mem_we;
   assign iord       = ctl_o.iord;
   assign alu_src_a  = ctl_o.alu_src_a;
   assign alu_src_b  = ctl_o.alu_src_b;
   assign imm_zext   = ctl_o.imm_zext;
   assign alu_op     = ctl_o.alu_op;
   assign pc_src     = ctl_o.pc_src;
   assign illegal    = ctl_o.illegal;
   assign state      = reset ? ST_FETCH : state_q;

`ifdef CONTROL_PERF_EN
   logic [PERF_W-1:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q + PERF_W'(1);
      instr_cnt_d = instr_cnt_q;
      if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_TRAP)
         instr_cnt_d = instr_cnt_q + PERF_W'(1);
   end

   // cycle_cnt includes the current cycle, so the first active cycle reads 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_q <= PERF_W'(1);
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = reset ? '0 : cycle_cnt_q;
   assign instr_cnt = reset ? '0 : instr_cnt_q;
`endif

endmodule
